maptable_module: RTL and testbench

MAPTABLE_MODULE -- requirements
Module: maptable

---
 rtl/maptable_module.sv | 118 +++++++++++
 tb/tb_maptable_module.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/maptable_module.sv
// ============================================================================
// Module   : maptable_module
// Brief    : Register rename map table with per-register ready bits and
//            registered rs1/rs2 lookups. Optional MAPTABLE_WB_FWD_EN forwards
//            a same-edge writeback into the registered ready bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

package maptable_pkg;
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } R_TYPE;

    typedef struct packed {
        R_TYPE r;
    } INST;

    typedef struct packed {
        logic [`ROB_TAG_LEN-1:0] rob_tag_val;
        logic                    rob_tag_ready;
    } MAPTABLE_PACKET;
endpackage

module maptable_module
    import maptable_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  INST                     inst,
    input  logic [4:0]              rd,
    input  logic [`ROB_TAG_LEN-1:0] rob_entry_in,
    input  logic                    valid_wb,
    input  logic [4:0]              rd_wb,
    input  logic [`ROB_TAG_LEN-1:0] rob_entry_wb,
    input  logic                    commit,
    input  logic [4:0]              rd_commit,
    input  logic [`ROB_TAG_LEN-1:0] rob_entry_commit,
    output MAPTABLE_PACKET          maptable_packet_rs1,
    output MAPTABLE_PACKET          maptable_packet_rs2
);

    localparam int c_NUM_REGS = 32;

    logic [`ROB_TAG_LEN-1:0] maptable        [c_NUM_REGS];
    logic                    ready_tag_table [c_NUM_REGS];

    logic [4:0]              w_rs1;
    logic [4:0]              w_rs2;
    logic [`ROB_TAG_LEN-1:0] w_tag_rs1;
    logic [`ROB_TAG_LEN-1:0] w_tag_rs2;
    logic                    w_rdy_rs1;
    logic                    w_rdy_rs2;
    logic                    w_wb_hit;
    logic                    w_commit_hit;
    logic                    w_unused_inst;

    assign w_rs1     = inst.r.rs1;
    assign w_rs2     = inst.r.rs2;
    assign w_tag_rs1 = maptable[w_rs1];
    assign w_tag_rs2 = maptable[w_rs2];

`ifdef MAPTABLE_WB_FWD_EN
    assign w_rdy_rs1 = ready_tag_table[w_rs1] |
                       (valid_wb && (w_tag_rs1 != '0) && (w_tag_rs1 == rob_entry_wb));
    assign w_rdy_rs2 = ready_tag_table[w_rs2] |
                       (valid_wb && (w_tag_rs2 != '0) && (w_tag_rs2 == rob_entry_wb));
`else
    assign w_rdy_rs1 = ready_tag_table[w_rs1];
    assign w_rdy_rs2 = ready_tag_table[w_rs2];
`endif

    // Tag compare protects against a register renamed since the producer issued.
    assign w_wb_hit     = valid_wb && (rob_entry_wb != '0) &&
                          (maptable[rd_wb] == rob_entry_wb);
    assign w_commit_hit = commit && (rob_entry_commit != '0) &&
                          (maptable[rd_commit] == rob_entry_commit);

    assign w_unused_inst = ^{inst.r.funct7, inst.r.funct3, inst.r.rd, inst.r.opcode};

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                maptable[i]        <= '0;
                ready_tag_table[i] <= 1'b0;
            end
            maptable_packet_rs1 <= '0;
            maptable_packet_rs2 <= '0;
        end else begin
            // Later assignments win: allocation > commit > writeback.
            if (w_wb_hit) begin
                ready_tag_table[rd_wb] <= 1'b1;
            end
            if (w_commit_hit) begin
                maptable[rd_commit]        <= '0;
                ready_tag_table[rd_commit] <= 1'b0;
            end
            if (rd != 5'd0) begin
                maptable[rd]        <= rob_entry_in;
                ready_tag_table[rd] <= 1'b0;
            end
            maptable_packet_rs1 <= '{rob_tag_val: w_tag_rs1, rob_tag_ready: w_rdy_rs1};
            maptable_packet_rs2 <= '{rob_tag_val: w_tag_rs2, rob_tag_ready: w_rdy_rs2};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_maptable_module.sv
// Testbench for maptable_module: directed scenarios plus random traffic
// compared against a per-register behavioural model.
`default_nettype none

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module tb_maptable_module;
    import maptable_pkg::*;

    localparam int TW = `ROB_TAG_LEN;

    logic           clock;
    logic           reset;
    INST            inst;
    logic [4:0]     rd;
    logic [TW-1:0]  rob_entry_in;
    logic           valid_wb;
    logic [4:0]     rd_wb;
    logic [TW-1:0]  rob_entry_wb;
    logic           commit;
    logic [4:0]     rd_commit;
    logic [TW-1:0]  rob_entry_commit;
    MAPTABLE_PACKET maptable_packet_rs1;
    MAPTABLE_PACKET maptable_packet_rs2;

    int checks = 0;
    int errors = 0;

    // Reference model state: architectural register -> tag / ready
    int m_tag [32];
    int m_rdy [32];
    int exp_pk1;
    int exp_pk2;

    maptable_module dut (
        .clock               (clock),
        .reset               (reset),
        .inst                (inst),
        .rd                  (rd),
        .rob_entry_in        (rob_entry_in),
        .valid_wb            (valid_wb),
        .rd_wb               (rd_wb),
        .rob_entry_wb        (rob_entry_wb),
        .commit              (commit),
        .rd_commit           (rd_commit),
        .rob_entry_commit    (rob_entry_commit),
        .maptable_packet_rs1 (maptable_packet_rs1),
        .maptable_packet_rs2 (maptable_packet_rs2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pk(input int tag, input int rdy);
        return (tag << 1) | rdy;
    endfunction

    function automatic int lookup(input int r);
        int rdy;
        rdy = m_rdy[r];
`ifdef MAPTABLE_WB_FWD_EN
        if (valid_wb && m_tag[r] != 0 && m_tag[r] == int'(rob_entry_wb)) rdy = 1;
`endif
        return pk(m_tag[r], rdy);
    endfunction

    task automatic idle();
        reset = 0; inst = '0; rd = 0; rob_entry_in = 0;
        valid_wb = 0; rd_wb = 0; rob_entry_wb = 0;
        commit = 0; rd_commit = 0; rob_entry_commit = 0;
    endtask

    // Advance one edge: predict from pre-edge model, clock, then compare everything.
    task automatic step();
        int nt [32];
        int nr [32];
        if (reset) begin
            exp_pk1 = 0; exp_pk2 = 0;
            for (int r = 0; r < 32; r++) begin nt[r] = 0; nr[r] = 0; end
        end else begin
            exp_pk1 = lookup(int'(inst.r.rs1));
            exp_pk2 = lookup(int'(inst.r.rs2));
            for (int r = 0; r < 32; r++) begin
                nt[r] = m_tag[r]; nr[r] = m_rdy[r];
                if (r != 0 && r == int'(rd)) begin
                    nt[r] = int'(rob_entry_in); nr[r] = 0;
                end else if (commit && r == int'(rd_commit) && rob_entry_commit != 0
                             && m_tag[r] == int'(rob_entry_commit)) begin
                    nt[r] = 0; nr[r] = 0;
                end else if (valid_wb && r == int'(rd_wb) && rob_entry_wb != 0
                             && m_tag[r] == int'(rob_entry_wb)) begin
                    nr[r] = 1;
                end
            end
        end
        @(posedge clock);
        #1;
        m_tag = nt; m_rdy = nr;
        check("pk_rs1", 32'({maptable_packet_rs1.rob_tag_val, maptable_packet_rs1.rob_tag_ready}), exp_pk1);
        check("pk_rs2", 32'({maptable_packet_rs2.rob_tag_val, maptable_packet_rs2.rob_tag_ready}), exp_pk2);
        for (int r = 0; r < 32; r++) begin
            check($sformatf("map[%0d]", r), 32'(dut.maptable[r]), m_tag[r]);
            check($sformatf("rdy[%0d]", r), 32'(dut.ready_tag_table[r]), m_rdy[r]);
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin m_tag[r] = 0; m_rdy[r] = 0; end
        idle();
        reset = 1;
        step();
        step();

        // Basic allocation and one-cycle lookup latency
        idle(); rd = 1; rob_entry_in = 1; inst.r.rs1 = 0; inst.r.rs2 = 3;
        step();
        check("first_rs1", 32'(maptable_packet_rs1), 0);
        check("first_rs2", 32'(maptable_packet_rs2), 0);
        idle(); rd = 2; rob_entry_in = 2; inst.r.rs2 = 1;
        step();
        check("rs2_r1", 32'(maptable_packet_rs2), pk(1, 0));

        // Self-dependence with concurrent writeback on another register
        idle(); rd = 3; rob_entry_in = 4; inst.r.rs1 = 3;
        valid_wb = 1; rd_wb = 1; rob_entry_wb = 1;
        step();
        check("selfdep_rs1", 32'(maptable_packet_rs1), pk(0, 0));
        check("selfdep_map3", 32'(dut.maptable[3]), 4);
        check("selfdep_rdy1", 32'(dut.ready_tag_table[1]), 1);

        // Stale writeback ignored, matching writeback sets ready
        idle(); rd = 2; rob_entry_in = 6;
        step();
        idle(); valid_wb = 1; rd_wb = 2; rob_entry_wb = 2;
        step();
        check("stale_rdy2", 32'(dut.ready_tag_table[2]), 0);
        idle(); valid_wb = 1; rd_wb = 3; rob_entry_wb = 4;
        step();
        idle(); inst.r.rs2 = 3;
        step();
        check("wb_rs2_r3", 32'(maptable_packet_rs2), pk(4, 1));

        // Commit match clears, mismatch leaves entry alone
        idle(); commit = 1; rd_commit = 2; rob_entry_commit = 6;
        step();
        check("commit_map2", 32'(dut.maptable[2]), 0);
        idle(); rd = 1; rob_entry_in = 5;
        step();
        idle(); commit = 1; rd_commit = 1; rob_entry_commit = 3;
        step();
        check("commit_miss_map1", 32'(dut.maptable[1]), 5);

        // Allocation beats matching commit; reset beats allocation
        idle(); rd = 2; rob_entry_in = 8;
        step();
        idle(); rd = 2; rob_entry_in = 9; commit = 1; rd_commit = 2; rob_entry_commit = 8;
        step();
        check("prio_map2", 32'(dut.maptable[2]), 9);
        check("prio_rdy2", 32'(dut.ready_tag_table[2]), 0);
        idle(); reset = 1; rd = 4; rob_entry_in = 3;
        step();
        check("rst_map4", 32'(dut.maptable[4]), 0);

        // Lookup with same-edge writeback of the looked-up tag
        idle(); rd = 3; rob_entry_in = 4;
        step();
        idle(); inst.r.rs1 = 3; valid_wb = 1; rd_wb = 3; rob_entry_wb = 4;
        step();
`ifdef MAPTABLE_WB_FWD_EN
        check("fwd_rs1", 32'(maptable_packet_rs1), pk(4, 1));
`else
        check("fwd_rs1", 32'(maptable_packet_rs1), pk(4, 0));
`endif

        // Random traffic on a small register window to force collisions
        for (int n = 0; n < 400; n++) begin
            idle();
            reset            = ($urandom_range(0, 49) == 0);
            inst.r.rs1       = 5'($urandom_range(0, 7));
            inst.r.rs2       = 5'($urandom_range(0, 7));
            rd               = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 7)) : 5'd0;
            rob_entry_in     = TW'($urandom_range(1, 15));
            valid_wb         = 1'($urandom_range(0, 1));
            rd_wb            = 5'($urandom_range(0, 7));
            rob_entry_wb     = ($urandom_range(0, 2) != 0) ? TW'(m_tag[rd_wb]) : TW'($urandom_range(0, 15));
            commit           = ($urandom_range(0, 3) == 0);
            rd_commit        = 5'($urandom_range(0, 7));
            rob_entry_commit = ($urandom_range(0, 2) != 0) ? TW'(m_tag[rd_commit]) : TW'($urandom_range(0, 15));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
